ccff_chain_loader: RTL and testbench

//  Upstream feeder of the configuration-chain (ccff_head -> ccff_tail) through the switch/connection blocks.

---
 rtl/ccff_chain_loader.sv | 148 ++++++++++++++
 tb/tb_ccff_chain_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Serialises valid/ready bitstream words MSB-first onto the configuration chain head.
// Optional readback of the outgoing chain contents is enabled with CCFF_READBACK_EN.
module ccff_chain_loader #(
   parameter int DATA_W    = 32,
   parameter int CHAIN_LEN = 8,
   parameter int CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done
`ifdef CCFF_READBACK_EN
   ,
   output logic [DATA_W-1:0] rb_data,
   output logic              rb_valid
`endif
);

   localparam int WB_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

   state_t            state;
   logic [DATA_W-1:0] word_reg;
   logic [WB_W-1:0]   word_bits;
   logic [CNT_W-1:0]  bits_left;
   logic              last_bit;

   always_comb begin
      last_bit = (bits_left == CNT_W'(1));
   end

   // Registered outputs always describe the bit currently presented to the chain;
   // s_ready rises in the cycle the last bit of a word is shown so the next word follows without a bubble.
   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state         <= IDLE;
         s_ready       <= 1'b0;
         ccff_head     <= 1'b0;
         ccff_shift_en <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         word_reg      <= '0;
         word_bits     <= '0;
         bits_left     <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               ccff_shift_en <= 1'b0;
               if (start) begin
                  state     <= FETCH;
                  busy      <= 1'b1;
                  s_ready   <= 1'b1;
                  bits_left <= CNT_W'(CHAIN_LEN);
                  word_bits <= '0;
               end
            end
            FETCH, SHIFT: begin
               if (bits_left == '0) begin
                  state         <= DONE;
                  s_ready       <= 1'b0;
                  ccff_shift_en <= 1'b0;
                  busy          <= 1'b0;
                  done          <= 1'b1;
               end else if (word_bits != '0) begin
                  state         <= SHIFT;
                  ccff_head     <= word_reg[DATA_W-1];
                  ccff_shift_en <= 1'b1;
                  word_reg      <= word_reg << 1;
                  word_bits     <= word_bits - WB_W'(1);
                  bits_left     <= bits_left - CNT_W'(1);
                  s_ready       <= (word_bits == WB_W'(1)) && !last_bit;
               end else if (s_valid && s_ready) begin
                  state         <= SHIFT;
                  ccff_head     <= s_data[DATA_W-1];
                  ccff_shift_en <= 1'b1;
                  word_reg      <= s_data << 1;
                  word_bits     <= WB_W'(DATA_W - 1);
                  bits_left     <= bits_left - CNT_W'(1);
                  s_ready       <= (DATA_W == 1) && !last_bit;
               end else begin
                  state         <= FETCH;
                  ccff_shift_en <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef CCFF_READBACK_EN
   localparam int RB_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] rb_shift;
   logic [DATA_W-1:0] rb_next;
   logic [RB_W-1:0]   rb_cnt;
   logic [RB_W-1:0]   rb_cnt_next;
   logic              rb_flush;

   // bits_left is zero exactly while the final bit of the load is enabled.
   always_comb begin
      rb_next     = (rb_shift << 1) | DATA_W'(ccff_tail);
      rb_cnt_next = rb_cnt + RB_W'(1);
      rb_flush    = (rb_cnt_next == RB_W'(DATA_W)) || (bits_left == '0);
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         rb_shift <= '0;
         rb_cnt   <= '0;
         rb_data  <= '0;
         rb_valid <= 1'b0;
      end else begin
         rb_valid <= 1'b0;
         if (ccff_shift_en) begin
            if (rb_flush) begin
               rb_data  <= rb_next << (RB_W'(DATA_W) - rb_cnt_next);
               rb_valid <= 1'b1;
               rb_shift <= '0;
               rb_cnt   <= '0;
            end else begin
               rb_shift <= rb_next;
               rb_cnt   <= rb_cnt_next;
            end
         end
      end
   end
`else
   logic tail_unused;
   always_comb begin
      tail_unused = ccff_tail;
   end
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: an 8-bit chain instance (with chain model) and a 6-bit instance.
module tb_ccff_chain_loader;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // selected-instance stimulus and observation
   bit         sel6;
   logic       start_x, s_valid_x;
   logic [3:0] s_data_x;
   logic       s_ready_x, head_x, en_x, busy_x, done_x;

   logic       start8, s_valid8, s_ready8, head8, en8, busy8, done8, tail8;
   logic [3:0] s_data8;
   logic       start6, s_valid6, s_ready6, head6, en6, busy6, done6;
   logic [3:0] s_data6;
`ifdef CCFF_READBACK_EN
   logic [3:0] rb_data8, rb_data6;
   logic       rb_valid8, rb_valid6;
`endif

   assign start8    = sel6 ? 1'b0 : start_x;
   assign s_valid8  = sel6 ? 1'b0 : s_valid_x;
   assign s_data8   = sel6 ? 4'h0 : s_data_x;
   assign start6    = sel6 ? start_x : 1'b0;
   assign s_valid6  = sel6 ? s_valid_x : 1'b0;
   assign s_data6   = sel6 ? s_data_x : 4'h0;
   assign s_ready_x = sel6 ? s_ready6 : s_ready8;
   assign head_x    = sel6 ? head6 : head8;
   assign en_x      = sel6 ? en6 : en8;
   assign busy_x    = sel6 ? busy6 : busy8;
   assign done_x    = sel6 ? done6 : done8;

   ccff_chain_loader #(.DATA_W(4), .CHAIN_LEN(8), .CNT_W(16)) dut8 (
      .prog_clk(clk), .prog_reset(rst), .start(start8), .s_data(s_data8), .s_valid(s_valid8),
      .s_ready(s_ready8), .ccff_head(head8), .ccff_shift_en(en8), .ccff_tail(tail8),
      .busy(busy8), .done(done8)
`ifdef CCFF_READBACK_EN
      , .rb_data(rb_data8), .rb_valid(rb_valid8)
`endif
   );

   ccff_chain_loader #(.DATA_W(4), .CHAIN_LEN(6), .CNT_W(16)) dut6 (
      .prog_clk(clk), .prog_reset(rst), .start(start6), .s_data(s_data6), .s_valid(s_valid6),
      .s_ready(s_ready6), .ccff_head(head6), .ccff_shift_en(en6), .ccff_tail(1'b0),
      .busy(busy6), .done(done6)
`ifdef CCFF_READBACK_EN
      , .rb_data(rb_data6), .rb_valid(rb_valid6)
`endif
   );

   // 8-bit chain model fed by dut8
   logic [7:0] chain8;
   logic       preload;
   logic [7:0] preload_val;
   always @(posedge clk) begin
      if (preload) chain8 <= preload_val;
      else if (en8) chain8 <= {chain8[6:0], head8};
   end
   assign tail8 = chain8[7];

   int checks = 0;
   int errors = 0;

   // load description and per-load observations
   int         ld_n;
   logic [3:0] ld_words[4];
   int         ld_gap[4];
   int         cl;
   logic       exp_q[$];
   logic       obs_q[$];
   logic [3:0] rb_q[$];
   int         n_en, n_done, n_bubble, n_extra, n_hold_err, first_en;
   bit         timed_out;
   logic       busy_first;

   // Drives one load and records what the DUT did; expected bits are queued on each accepted word.
   // A word's gap counts cycles s_valid stays low while the DUT is asking for it.
   task automatic run_load(input int start_again_at, input int reset_at, input int max_cyc);
      int idx, gap, pushed, cyc, linger;
      bit accept, waiting;
      logic prev_head;
      exp_q.delete(); obs_q.delete(); rb_q.delete();
      n_en = 0; n_done = 0; n_bubble = 0; n_extra = 0; n_hold_err = 0; first_en = 0;
      timed_out = 0; idx = 0; pushed = 0; linger = -1;
      gap = ld_gap[0];
      start_x = 1'b1;
      @(posedge clk); #1;
      start_x = 1'b0;
      cyc = 1;
      busy_first = busy_x;
      prev_head = head_x;
      while (1) begin
         if (idx < ld_n && gap == 0) begin
            s_valid_x = 1'b1;
            s_data_x  = ld_words[idx];
         end else begin
            s_valid_x = 1'b0;
         end
         accept  = s_valid_x && s_ready_x;
         waiting = (idx < ld_n) && (gap > 0) && s_ready_x;
         @(posedge clk); #1;
         cyc++;
         start_x = 1'b0;
         if (accept) begin
            if (pushed >= cl) n_extra++;
            for (int b = 3; b >= 0; b--) begin
               if (pushed < cl) begin
                  exp_q.push_back(ld_words[idx][b]);
                  pushed++;
               end
            end
            idx++;
            if (idx < ld_n) gap = ld_gap[idx];
         end else if (waiting) begin
            gap--;
         end
         if (en_x) begin
            obs_q.push_back(head_x);
            n_en++;
            if (n_en == 1) first_en = cyc;
            if (n_en == start_again_at) start_x = 1'b1;
            if (n_en == reset_at) begin
               rst = 1'b1;
               s_valid_x = 1'b0;
               return;
            end
         end else if (n_en > 0 && n_en < cl) begin
            n_bubble++;
            if (head_x !== prev_head) n_hold_err++;
         end
         prev_head = head_x;
`ifdef CCFF_READBACK_EN
         if (!sel6 && rb_valid8) rb_q.push_back(rb_data8);
`endif
         if (done_x) n_done++;
         if (done_x && linger < 0) linger = 3;
         if (linger == 0) break;
         if (linger > 0) linger--;
         if (cyc >= max_cyc) begin
            timed_out = 1;
            break;
         end
      end
      s_valid_x = 1'b0;
   endtask

   task automatic test_reset();
      for (int s = 0; s < 2; s++) begin
         sel6 = (s == 1);
         #1;
         checks++;
         if ({s_ready_x, head_x, en_x, busy_x, done_x} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs inst=%0d got %b want 00000", s, {s_ready_x, head_x, en_x, busy_x, done_x});
         end
      end
`ifdef CCFF_READBACK_EN
      checks++;
      if ({rb_data8, rb_valid8} !== 5'b0) begin
         errors++;
         $display("FAIL reset_rb got %h/%b want 0/0", rb_data8, rb_valid8);
      end
`endif
      sel6 = 0;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic e, o;
      sel6 = 0; cl = 8; ld_n = 2;
      ld_words[0] = 4'hA; ld_words[1] = 4'h5; ld_gap[0] = 0; ld_gap[1] = 0;
      run_load(0, 0, 60);
      checks++;
      if (timed_out) begin errors++; $display("FAIL t1_timeout no done within budget"); end
      checks++;
      if (busy_first !== 1'b1) begin errors++; $display("FAIL t1_busy_latency got %b want 1", busy_first); end
      checks++;
      if (first_en < 2) begin errors++; $display("FAIL t1_first_shift_latency got %0d want >=2", first_en); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL t1_bit_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL t1_bit got %b want %b", o, e); end
      end
      checks++;
      if (n_bubble != 0) begin errors++; $display("FAIL t1_bubbles got %0d want 0", n_bubble); end
      checks++;
      if (n_en != 8 || n_done != 1) begin
         errors++; $display("FAIL t1_counts got en=%0d done=%0d want en=8 done=1", n_en, n_done);
      end
   endtask

   task automatic test_stall();
      logic e, o;
      sel6 = 0; cl = 8; ld_n = 2;
      ld_words[0] = 4'hA; ld_words[1] = 4'h5; ld_gap[0] = 0; ld_gap[1] = 5;
      run_load(0, 0, 60);
      checks++;
      if (timed_out) begin errors++; $display("FAIL t2_timeout no done within budget"); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL t2_bit_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL t2_bit got %b want %b", o, e); end
      end
      checks++;
      if (n_bubble != 5) begin errors++; $display("FAIL t2_stall_cycles got %0d want 5", n_bubble); end
      checks++;
      if (n_hold_err != 0) begin errors++; $display("FAIL t2_head_hold got %0d changes want 0", n_hold_err); end
      checks++;
      if (n_en != 8 || n_done != 1) begin
         errors++; $display("FAIL t2_counts got en=%0d done=%0d want en=8 done=1", n_en, n_done);
      end
   endtask

   task automatic test_partial_word();
      logic e, o;
      sel6 = 1; cl = 6; ld_n = 3;
      ld_words[0] = 4'hF; ld_words[1] = 4'hB; ld_words[2] = 4'h7;
      ld_gap[0] = 0; ld_gap[1] = 0; ld_gap[2] = 0;
      run_load(0, 0, 60);
      checks++;
      if (timed_out) begin errors++; $display("FAIL t3_timeout no done within budget"); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL t3_bit_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL t3_bit got %b want %b", o, e); end
      end
      checks++;
      if (n_extra != 0) begin errors++; $display("FAIL t3_extra_word got %0d accepted want 0", n_extra); end
      checks++;
      if (n_en != 6 || n_done != 1) begin
         errors++; $display("FAIL t3_counts got en=%0d done=%0d want en=6 done=1", n_en, n_done);
      end
      sel6 = 0;
   endtask

   task automatic test_start_while_busy();
      logic e, o;
      sel6 = 0; cl = 8; ld_n = 2;
      ld_words[0] = 4'hA; ld_words[1] = 4'h5; ld_gap[0] = 0; ld_gap[1] = 0;
      run_load(3, 0, 60);
      checks++;
      if (timed_out) begin errors++; $display("FAIL t4_timeout no done within budget"); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL t4_bit got %b want %b", o, e); end
      end
      checks++;
      if (n_en != 8 || n_done != 1) begin
         errors++; $display("FAIL t4_counts got en=%0d done=%0d want en=8 done=1", n_en, n_done);
      end
      checks++;
      if (busy_x !== 1'b0) begin errors++; $display("FAIL t4_idle_after got busy=%b want 0", busy_x); end
   endtask

   task automatic test_reset_mid_load();
      logic e, o;
      sel6 = 0; cl = 8; ld_n = 2;
      ld_words[0] = 4'hA; ld_words[1] = 4'h5; ld_gap[0] = 0; ld_gap[1] = 0;
      run_load(0, 5, 60);
      @(posedge clk); #1;
      checks++;
      if ({s_ready_x, head_x, en_x, busy_x, done_x} !== 5'b0) begin
         errors++; $display("FAIL t5_reset_outputs got %b want 00000", {s_ready_x, head_x, en_x, busy_x, done_x});
      end
      // start together with reset must be dropped
      start_x = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start_x = 1'b0;
      checks++;
      if ({busy_x, s_ready_x} !== 2'b00) begin
         errors++; $display("FAIL t5_start_during_reset got busy/ready=%b want 00", {busy_x, s_ready_x});
      end
      @(posedge clk); #1;
      checks++;
      if (busy_x !== 1'b0) begin errors++; $display("FAIL t5_still_idle got busy=%b want 0", busy_x); end
      ld_words[0] = 4'h3; ld_words[1] = 4'hC;
      run_load(0, 0, 60);
      checks++;
      if (timed_out) begin errors++; $display("FAIL t5_timeout no done within budget"); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL t5_bit got %b want %b", o, e); end
      end
      checks++;
      if (n_en != 8 || n_done != 1) begin
         errors++; $display("FAIL t5_counts got en=%0d done=%0d want en=8 done=1", n_en, n_done);
      end
   endtask

`ifdef CCFF_READBACK_EN
   task automatic test_readback();
      logic [3:0] want[2];
      want[0] = 4'h3; want[1] = 4'hC;
      preload_val = 8'h3C; preload = 1'b1;
      @(posedge clk); #1;
      preload = 1'b0;
      sel6 = 0; cl = 8; ld_n = 2;
      ld_words[0] = 4'hF; ld_words[1] = 4'hF; ld_gap[0] = 0; ld_gap[1] = 0;
      run_load(0, 0, 60);
      checks++;
      if (rb_q.size() != 2) begin errors++; $display("FAIL t6_rb_count got %0d want 2", rb_q.size()); end
      for (int i = 0; i < 2; i++) begin
         if (rb_q.size() > 0) begin
            checks++;
            if (rb_q[0] !== want[i]) begin
               errors++; $display("FAIL t6_rb_word%0d got %h want %h", i, rb_q[0], want[i]);
            end
            void'(rb_q.pop_front());
         end
      end
      checks++;
      if (chain8 !== 8'hFF) begin errors++; $display("FAIL t6_chain got %h want ff", chain8); end
   endtask
`endif

   initial begin
      rst = 1'b1; start_x = 1'b0; s_valid_x = 1'b0; s_data_x = 4'h0; sel6 = 0;
      preload = 1'b1; preload_val = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      preload = 1'b0;
      test_reset();
      test_back_to_back();
      test_stall();
      test_partial_word();
      test_start_while_busy();
      test_reset_mid_load();
`ifdef CCFF_READBACK_EN
      test_readback();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
